// File: rtl/alu_wide_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_wide_seq
//  Description : Sequencer that runs 16-bit AND/XOR/SHL/SHR/ADD operations by
//                driving a shared 8-bit combinational ALU once per byte, with
//                an extra carry-fix step for ADD when the low byte carries.
//                Optional macro ALU_WIDE_SEQ_ROTATE_EN adds ROL (101) and
//                ROR (110) built from the ALU shift encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_wide_seq #(
    parameter logic [2:0] IDLE_OP = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  wop,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry,
    output logic        zf,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_r1,
    output logic [7:0]  alu_r2,
    input  logic [7:0]  alu_out,
    input  logic [1:0]  alu_ovf
);

    // Wide opcodes; the first five also equal the ALU's own encodings.
    localparam logic [2:0] C_OP_AND = 3'b000;
    localparam logic [2:0] C_OP_XOR = 3'b001;
    localparam logic [2:0] C_OP_SHL = 3'b010;
    localparam logic [2:0] C_OP_SHR = 3'b011;
    localparam logic [2:0] C_OP_ADD = 3'b100;
`ifdef ALU_WIDE_SEQ_ROTATE_EN
    localparam logic [2:0] C_OP_ROL = 3'b101;
    localparam logic [2:0] C_OP_ROR = 3'b110;
`endif

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  wop_q,    wop_d;
    logic [15:0] a_q,      a_d;
    logic [15:0] b_q,      b_d;
    logic [7:0]  lo_q,     lo_d;      // result byte 0 from the LO step
    logic [7:0]  hi_q,     hi_d;      // uncorrected byte 1, input to the FIX step
    logic        lc_q,     lc_d;      // low-byte carry of ADD
    logic        hc_q,     hc_d;      // high-byte carry of ADD
    logic [15:0] result_q, result_d;
    logic        carry_q,  carry_d;
    logic        zf_q,     zf_d;

    logic        w_is_add;
    logic        w_supported;
    logic        w_update;
    logic [15:0] w_fin_word;
    logic        w_fin_carry;

    // Only bit 0 of the ALU overflow carries information (max sum 9'h1FE).
    logic        w_unused_ovf;
    assign w_unused_ovf = alu_ovf[1];

    assign w_is_add = (wop_q == C_OP_ADD);

    // Opcodes this build knows how to sequence; anything else yields zero.
    always_comb begin
        w_supported = (wop_q <= C_OP_ADD);
`ifdef ALU_WIDE_SEQ_ROTATE_EN
        if ((wop_q == C_OP_ROL) || (wop_q == C_OP_ROR)) begin
            w_supported = 1'b1;
        end
`endif
    end

    // ALU drive: purely a function of the current step and latched operands.
    always_comb begin
        alu_op = IDLE_OP;
        alu_r1 = 8'h00;
        alu_r2 = 8'h00;
        case (state_q)
            ST_LO: begin
                case (wop_q)
                    C_OP_AND, C_OP_XOR, C_OP_ADD: begin
                        alu_op = wop_q;
                        alu_r1 = a_q[7:0];
                        alu_r2 = b_q[7:0];
                    end
                    C_OP_SHL: begin
                        // Zero shifts into bit 0.
                        alu_op = C_OP_SHL;
                        alu_r1 = 8'h00;
                        alu_r2 = a_q[7:0];
                    end
                    C_OP_SHR: begin
                        // A[8] shifts into bit 7 of the low byte.
                        alu_op = C_OP_SHR;
                        alu_r1 = a_q[15:8];
                        alu_r2 = a_q[7:0];
                    end
`ifdef ALU_WIDE_SEQ_ROTATE_EN
                    C_OP_ROL: begin
                        // A[15] wraps around into bit 0.
                        alu_op = C_OP_SHL;
                        alu_r1 = a_q[15:8];
                        alu_r2 = a_q[7:0];
                    end
                    C_OP_ROR: begin
                        alu_op = C_OP_SHR;
                        alu_r1 = a_q[15:8];
                        alu_r2 = a_q[7:0];
                    end
`endif
                    default: begin
                        alu_op = wop_q;
                    end
                endcase
            end
            ST_HI: begin
                case (wop_q)
                    C_OP_AND, C_OP_XOR, C_OP_ADD: begin
                        alu_op = wop_q;
                        alu_r1 = a_q[15:8];
                        alu_r2 = b_q[15:8];
                    end
                    C_OP_SHL: begin
                        // A[7] shifts into bit 8.
                        alu_op = C_OP_SHL;
                        alu_r1 = a_q[7:0];
                        alu_r2 = a_q[15:8];
                    end
                    C_OP_SHR: begin
                        // Zero shifts into bit 15.
                        alu_op = C_OP_SHR;
                        alu_r1 = 8'h00;
                        alu_r2 = a_q[15:8];
                    end
`ifdef ALU_WIDE_SEQ_ROTATE_EN
                    C_OP_ROL: begin
                        alu_op = C_OP_SHL;
                        alu_r1 = a_q[7:0];
                        alu_r2 = a_q[15:8];
                    end
                    C_OP_ROR: begin
                        // A[0] wraps around into bit 15.
                        alu_op = C_OP_SHR;
                        alu_r1 = a_q[7:0];
                        alu_r2 = a_q[15:8];
                    end
`endif
                    default: begin
                        alu_op = wop_q;
                    end
                endcase
            end
            ST_FIX: begin
                // Propagate the low-byte carry into byte 1.
                alu_op = C_OP_ADD;
                alu_r1 = hi_q;
                alu_r2 = 8'h01;
            end
            default: begin
                alu_op = IDLE_OP;
            end
        endcase
    end

    // Next-state and datapath update for each sequencing step.
    always_comb begin
        state_d     = state_q;
        wop_d       = wop_q;
        a_d         = a_q;
        b_d         = b_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        lc_d        = lc_q;
        hc_d        = hc_q;
        result_d    = result_q;
        carry_d     = carry_q;
        zf_d        = zf_q;
        w_update    = 1'b0;
        w_fin_word  = {alu_out, lo_q};
        w_fin_carry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wop_d   = wop;
                    a_d     = a;
                    b_d     = b;
                    lc_d    = 1'b0;
                    hc_d    = 1'b0;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                lo_d    = alu_out;
                lc_d    = w_is_add & alu_ovf[0];
                state_d = ST_HI;
            end
            ST_HI: begin
                hi_d = alu_out;
                hc_d = w_is_add & alu_ovf[0];
                if (w_is_add && lc_q) begin
                    state_d = ST_FIX;
                end else begin
                    w_update    = 1'b1;
                    w_fin_carry = w_is_add & alu_ovf[0];
                    state_d     = ST_FIN;
                end
            end
            ST_FIX: begin
                // hc and fc are mutually exclusive, so OR gives the true carry.
                w_update    = 1'b1;
                w_fin_carry = hc_q | alu_ovf[0];
                state_d     = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Publish the final word so it is already valid in the DONE cycle.
        if (w_update) begin
            if (w_supported) begin
                result_d = w_fin_word;
                carry_d  = w_fin_carry;
                zf_d     = (w_fin_word == 16'h0000);
            end else begin
                result_d = 16'h0000;
                carry_d  = 1'b0;
                zf_d     = 1'b1;
            end
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            wop_q    <= 3'b000;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            lo_q     <= 8'h00;
            hi_q     <= 8'h00;
            lc_q     <= 1'b0;
            hc_q     <= 1'b0;
            result_q <= 16'h0000;
            carry_q  <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wop_q    <= wop_d;
            a_q      <= a_d;
            b_q      <= b_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            lc_q     <= lc_d;
            hc_q     <= hc_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zf_q     <= zf_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_FIN);
    assign result = result_q;
    assign carry  = carry_q;
    assign zf     = zf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_wide_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_wide_seq
//  Description : Directed self-checking bench for alu_wide_seq with a
//                behavioural model of the shared 8-bit ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wide_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  wop;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry;
    logic        zf;
    logic [2:0]  alu_op;
    logic [7:0]  alu_r1;
    logic [7:0]  alu_r2;
    logic [7:0]  alu_out;
    logic [1:0]  alu_ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_wide_seq #(.IDLE_OP(3'b000)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .wop     (wop),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .carry   (carry),
        .zf      (zf),
        .alu_op  (alu_op),
        .alu_r1  (alu_r1),
        .alu_r2  (alu_r2),
        .alu_out (alu_out),
        .alu_ovf (alu_ovf)
    );

    // 8-bit ALU: SHL shifts R2 left taking R1[7] in; SHR shifts R2 right taking R1[0] in.
    logic [8:0] sum9;
    always_comb begin
        sum9    = {1'b0, alu_r1} + {1'b0, alu_r2};
        alu_out = 8'h00;
        alu_ovf = 2'b00;
        case (alu_op)
            3'b000: alu_out = alu_r1 & alu_r2;
            3'b001: alu_out = alu_r1 ^ alu_r2;
            3'b010: alu_out = {alu_r2[6:0], alu_r1[7]};
            3'b011: alu_out = {alu_r1[0], alu_r2[7:1]};
            3'b100: begin
                alu_out = sum9[7:0];
                alu_ovf = {1'b0, sum9[8]};
            end
            default: alu_out = 8'h00;
        endcase
    end

    // Issue one op; report DONE latency (-1 on timeout) and the ALU drive seen in cycle 3.
    task automatic do_op(input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb,
                         output int lat, output logic [2:0] c3_op,
                         output logic [7:0] c3_r1, output logic [7:0] c3_r2);
        @(negedge clk);
        start = 1'b1;
        wop   = op;
        a     = va;
        b     = vb;
        @(posedge clk);
        lat   = -1;
        c3_op = 3'b000;
        c3_r1 = 8'h00;
        c3_r2 = 8'h00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 3) begin
                c3_op = alu_op;
                c3_r1 = alu_r1;
                c3_r2 = alu_r2;
            end
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        wop   = 3'b000;
        a     = 16'h0000;
        b     = 16'h0000;
        #12;
        total++;
        if ({busy, done, carry, zf, result, alu_op, alu_r1, alu_r2} !== 35'h0) begin
            bad++;
            $display("FAIL reset_state got busy=%b done=%b carry=%b zf=%b result=%h alu=%h/%h/%h exp all zero",
                     busy, done, carry, zf, result, alu_op, alu_r1, alu_r2);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        logic [15:0] rv [4];
        logic        cv [4];
        logic        zv [4];
        int          lv [4];
        logic [7:0]  fx [4];
        int          lat;
        logic [2:0]  o3;
        logic [7:0]  r1, r2;
        av = '{16'h00FF, 16'hFFFF, 16'h1234, 16'h8000};
        bv = '{16'h0001, 16'h0001, 16'h0101, 16'h8000};
        rv = '{16'h0100, 16'h0000, 16'h1335, 16'h0000};
        cv = '{1'b0, 1'b1, 1'b0, 1'b1};
        zv = '{1'b0, 1'b1, 1'b0, 1'b1};
        lv = '{4, 4, 3, 3};
        fx = '{8'h00, 8'hFF, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) begin
            do_op(3'b100, av[i], bv[i], lat, o3, r1, r2);
            total++;
            if (lat !== lv[i]) begin
                bad++;
                $display("FAIL add_latency[%0d] got=%0d exp=%0d", i, lat, lv[i]);
            end
            total++;
            if ({result, carry, zf} !== {rv[i], cv[i], zv[i]}) begin
                bad++;
                $display("FAIL add_result[%0d] got r=%h c=%b z=%b exp r=%h c=%b z=%b",
                         i, result, carry, zf, rv[i], cv[i], zv[i]);
            end
            if (lv[i] == 4) begin
                total++;
                if ({o3, r1, r2} !== {3'b100, fx[i], 8'h01}) begin
                    bad++;
                    $display("FAIL add_fix_drive[%0d] got op=%b r1=%h r2=%h exp op=100 r1=%h r2=01",
                             i, o3, r1, r2, fx[i]);
                end
            end
            @(negedge clk);
            total++;
            if ({done, busy} !== 2'b00) begin
                bad++;
                $display("FAIL add_done_pulse[%0d] got done=%b busy=%b exp 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_shift_logic();
        logic [2:0]  ov [5];
        logic [15:0] av [5];
        logic [15:0] bv [5];
        logic [15:0] rv [5];
        logic        zv [5];
        int          lat;
        logic [2:0]  o3;
        logic [7:0]  r1, r2;
        ov = '{3'b010, 3'b011, 3'b001, 3'b000, 3'b010};
        av = '{16'h8081, 16'h0181, 16'hA5A5, 16'hF0F0, 16'h8000};
        bv = '{16'hFFFF, 16'hFFFF, 16'hA5A5, 16'h3C3C, 16'h1234};
        rv = '{16'h0102, 16'h00C0, 16'h0000, 16'h3030, 16'h0000};
        zv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_op(ov[i], av[i], bv[i], lat, o3, r1, r2);
            total++;
            if (lat !== 3) begin
                bad++;
                $display("FAIL sl_latency[%0d] got=%0d exp=3", i, lat);
            end
            total++;
            if ({result, carry, zf} !== {rv[i], 1'b0, zv[i]}) begin
                bad++;
                $display("FAIL sl_result[%0d] got r=%h c=%b z=%b exp r=%h c=0 z=%b",
                         i, result, carry, zf, rv[i], zv[i]);
            end
        end
    endtask

    task automatic test_unsupported();
        int          lat;
        logic [2:0]  o3;
        logic [7:0]  r1, r2;
        do_op(3'b111, 16'hFFFF, 16'hFFFF, lat, o3, r1, r2);
        total++;
        if ({lat == 3, result, carry, zf} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL unsup_111 got lat=%0d r=%h c=%b z=%b exp lat=3 r=0000 c=0 z=1",
                     lat, result, carry, zf);
        end
`ifdef ALU_WIDE_SEQ_ROTATE_EN
        do_op(3'b101, 16'h8001, 16'h0000, lat, o3, r1, r2);
        total++;
        if ({lat == 3, result, carry, zf} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rol got lat=%0d r=%h c=%b z=%b exp lat=3 r=0003 c=0 z=0",
                     lat, result, carry, zf);
        end
        do_op(3'b110, 16'h8001, 16'h0000, lat, o3, r1, r2);
        total++;
        if ({lat == 3, result, carry, zf} !== {1'b1, 16'hC000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ror got lat=%0d r=%h c=%b z=%b exp lat=3 r=c000 c=0 z=0",
                     lat, result, carry, zf);
        end
`else
        do_op(3'b101, 16'h8001, 16'h0000, lat, o3, r1, r2);
        total++;
        if ({lat == 3, result, carry, zf} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL unsup_101 got lat=%0d r=%h c=%b z=%b exp lat=3 r=0000 c=0 z=1",
                     lat, result, carry, zf);
        end
`endif
    endtask

    task automatic test_busy_ignore();
        int          ndone;
        logic [15:0] first_r;
        logic        busy_c1;
        ndone   = 0;
        first_r = 16'hDEAD;
        busy_c1 = 1'b0;
        @(negedge clk);
        start = 1'b1;
        wop   = 3'b000;
        a     = 16'hF0F0;
        b     = 16'h3C3C;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                busy_c1 = busy;
                wop = 3'b001;
                a   = 16'h1111;
                b   = 16'h2222;
            end
            if (k == 3) start = 1'b0;
            if (done) begin
                if (ndone == 0) first_r = result;
                ndone++;
            end
        end
        total++;
        if (busy_c1 !== 1'b1) begin
            bad++;
            $display("FAIL busy_after_accept got=%b exp=1", busy_c1);
        end
        total++;
        if (ndone !== 1) begin
            bad++;
            $display("FAIL busy_done_count got=%0d exp=1", ndone);
        end
        total++;
        if (first_r !== 16'h3030) begin
            bad++;
            $display("FAIL busy_result got=%h exp=3030", first_r);
        end
    endtask

    task automatic test_reset_mid_op();
        int          ndone;
        int          lat;
        logic [2:0]  o3;
        logic [7:0]  r1, r2;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        wop   = 3'b100;
        a     = 16'hFFFF;
        b     = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, carry, zf, result, alu_op, alu_r1, alu_r2} !== 35'h0) begin
            bad++;
            $display("FAIL rst_mid_op got busy=%b done=%b carry=%b zf=%b result=%h alu=%h/%h/%h exp all zero",
                     busy, done, carry, zf, result, alu_op, alu_r1, alu_r2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++;
        if (ndone !== 0) begin
            bad++;
            $display("FAIL rst_no_done got=%0d exp=0", ndone);
        end
        do_op(3'b100, 16'h1234, 16'h0101, lat, o3, r1, r2);
        total++;
        if ({lat == 3, result, carry, zf} !== {1'b1, 16'h1335, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL rst_recover got lat=%0d r=%h c=%b z=%b exp lat=3 r=1335 c=0 z=0",
                     lat, result, carry, zf);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift_logic();
        test_unsupported();
        test_busy_ignore();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_wide_seq.md
Name: alu_wide_seq

Overview:
- Multi-cycle sequencer that performs 16-bit operations by driving the shared 8-bit combinational ALU (AND, XOR, SHL, SHR, ADD encodings 000-100) once per byte.
- Sits between the core's execute stage and the ALU instance.
- Latches 16-bit operands on START, issues low/high byte ALU steps plus a carry-fix step for ADD, and returns a registered 16-bit result with CARRY/ZF.

Parameters:
- IDLE_OP, 3'b000, ALU opcode driven while no operation is in flight.

Ports:
- CLK  input  1  clock, rising edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  request; accepted only when BUSY=0
- WOP  input  3  wide opcode: 000 AND, 001 XOR, 010 SHL, 011 SHR, 100 ADD, others unsupported
- A  input  16  operand A (shift source)
- B  input  16  operand B (ignored for shifts)
- BUSY  output  1  high from the cycle after accept until DONE cycle inclusive
- DONE  output  1  one-cycle completion pulse
- RESULT  output  16  registered result; held until next accept
- CARRY  output  1  ADD carry out of bit 15; 0 for other ops
- ZF  output  1  RESULT==16'h0000, valid with DONE and held
- ALU_OP  output  3  to ALU OP
- ALU_R1  output  8  to ALU R1
- ALU_R2  output  8  to ALU R2
- ALU_OUT  input  8  from ALU OUT
- ALU_OVF  input  2  from ALU OVERFLOW; only bit 0 is meaningful (sum <= 9'h1FE)

Behaviour:
- Reset (async, RST_N=0): state=IDLE; BUSY, DONE, CARRY, ZF = 0; RESULT = 0; internal operand and carry registers = 0. Reset mid-operation aborts immediately with no DONE pulse.
- States: IDLE -> LO -> HI -> (FIX, ADD only, if low carry=1) -> FIN -> IDLE.
- IDLE: START=1 latches WOP/A/B; next state LO. START while BUSY=1 is ignored (not queued).
- ALU drive is combinational from state and latched operands. In IDLE/FIN: ALU_OP=IDLE_OP, R1=R2=0.
- LO step (result byte 0 captured at end of cycle):
  - AND/XOR/ADD: R1=A[7:0], R2=B[7:0].
  - SHL: R2=A[7:0], R1=0, giving {A[6:0],0}.
  - SHR: R2=A[7:0], R1=A[15:8], giving {A[8],A[7:1]}.
  - ADD also captures lc=ALU_OVF[0].
- HI step (result byte 1):
  - AND/XOR/ADD: R1=A[15:8], R2=B[15:8].
  - SHL: R2=A[15:8], R1=A[7:0], giving {A[14:8],A[7]}.
  - SHR: R2=A[15:8], R1=0, giving {0,A[15:9]}.
  - ADD captures hc=ALU_OVF[0].
- FIX step (ADD with lc=1): ALU_OP=100, R1=result byte 1, R2=8'h01; byte 1 replaced by ALU_OUT; fc=ALU_OVF[0].
- CARRY = hc|fc; both can never be 1 together.
- Unsupported WOP: ALU_OP=WOP passed through (ALU returns 0); RESULT=0, ZF=1, CARRY=0.
- FIN: DONE=1, BUSY=1; RESULT/CARRY/ZF already valid this cycle. Next cycle returns to IDLE, DONE=0, and a new START may be accepted.
- Latency from accept cycle (cycle 0):
  - DONE at cycle 3 for all ops.
  - DONE at cycle 4 for ADD with low-byte carry.
  - Back-to-back throughput is 4 or 5 cycles per op.
- The ALU's own ZF output is not used; ZF is computed over all 16 bits.

Optional Feature:
- Macro ALU_WIDE_SEQ_ROTATE_EN.
- Defined: WOP 101 = ROL, 110 = ROR, both via the ALU shift encodings.
  - ROL: LO uses ALU_OP=010 with R1=A[15:8], giving {A[6:0],A[15]}; HI same as SHL.
  - ROR: HI uses ALU_OP=011 with R1=A[7:0], giving {A[0],A[15:9]}; LO same as SHR.
  - CARRY=0.
- Undefined: 101/110 are unsupported (RESULT=0, ZF=1).

Test Plan:
- ADD A=16'h00FF B=16'h0001 -> FIX step taken; DONE at cycle 4; RESULT=16'h0100, CARRY=0, ZF=0.
- ADD A=16'hFFFF B=16'h0001 -> DONE at cycle 4; RESULT=16'h0000, CARRY=1, ZF=1; ALU sees 8'hFF+8'h01 in FIX.
- SHL A=16'h8081 -> DONE at cycle 3, RESULT=16'h0102. SHR A=16'h0181 -> RESULT=16'h00C0. CARRY=0 for both.
- XOR A=B=16'hA5A5 -> RESULT=0, ZF=1 at cycle 3. AND A=16'hF0F0 B=16'h3C3C -> RESULT=16'h3030. START pulsed during BUSY is ignored; exactly one DONE per accepted op.
- RST_N low during HI step of ADD -> all outputs 0 immediately, no DONE; START after release completes normally. With macro defined: ROL 16'h8001 -> 16'h0003; ROR 16'h8001 -> 16'hC000.
